// File: rtl/ram1r2w_lvt_if.sv
// Request/response bundle for the two-write, one-read LVT RAM.
// The master issues reads and writes; the slave (the RAM) returns read data.
interface ram1r2w_lvt_if #(
    parameter int WIDTH    = 1,
    parameter int LG_DEPTH = 1
);
    logic                rd_en;
    logic [LG_DEPTH-1:0] rd_addr;
    logic                wr_en0;
    logic [LG_DEPTH-1:0] wr_addr0;
    logic [WIDTH-1:0]    wr_data0;
    logic                wr_en1;
    logic [LG_DEPTH-1:0] wr_addr1;
    logic [WIDTH-1:0]    wr_data1;
    logic                rd_valid;
    logic [WIDTH-1:0]    rd_data;

    modport master (
        output rd_en, rd_addr,
        output wr_en0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        input  rd_valid, rd_data
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wr_en0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/ram1r2w_lvt.sv
// Two-write-port, one-read-port RAM: one bank per write port plus a flop
// live-value table that remembers which bank last wrote each address.
module ram1r2w_lvt #(
    parameter int WIDTH    = 1,
    parameter int LG_DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    ram1r2w_lvt_if.slave  bus
);
    localparam int DEPTH = 2 ** LG_DEPTH;

    logic [WIDTH-1:0] bank0 [DEPTH];
    logic [WIDTH-1:0] bank1 [DEPTH];
    logic [DEPTH-1:0] lvt;

    logic [WIDTH-1:0] bank0_p1;
    logic [WIDTH-1:0] bank1_p1;
    logic             sel_q;
    logic             vld_p1;

    // Stage p0 -> p1: bank storage and registered read; contents are never reset,
    // but writes are dropped on any edge that sees reset high.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (bus.wr_en0) bank0[bus.wr_addr0] <= bus.wr_data0;
            if (bus.wr_en1) bank1[bus.wr_addr1] <= bus.wr_data1;
            if (bus.rd_en) begin
                bank0_p1 <= bank0[bus.rd_addr];
                bank1_p1 <= bank1[bus.rd_addr];
            end
        end
    end

    // Port 1's LVT update is ordered last so it wins an address collision;
    // the read samples the pre-update LVT bit, giving read-old behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvt    <= '0;
            sel_q  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (bus.wr_en0) lvt[bus.wr_addr0] <= 1'b0;
            if (bus.wr_en1) lvt[bus.wr_addr1] <= 1'b1;
            vld_p1 <= bus.rd_en;
            if (bus.rd_en) sel_q <= lvt[bus.rd_addr];
        end
    end

    // Stage p1 output: steer by the captured LVT bit, force zero when idle.
    always_comb begin
        bus.rd_valid = vld_p1;
        bus.rd_data  = '0;
        if (vld_p1) bus.rd_data = sel_q ? bank1_p1 : bank0_p1;
    end
endmodule

// File: tb/tb_ram1r2w_lvt.sv
// Directed and randomized checks of the two-write-port LVT RAM against
// hand-computed values and a small read-old reference model.
module tb_ram1r2w_lvt;
    localparam int W  = 32;
    localparam int LG = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ram1r2w_lvt_if #(.WIDTH(W), .LG_DEPTH(LG)) bus ();

    ram1r2w_lvt #(.WIDTH(W), .LG_DEPTH(LG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en  = 1'b0;
        bus.wr_en0 = 1'b0;
        bus.wr_en1 = 1'b0;
    endtask

    task automatic wr0(input logic [LG-1:0] a, input logic [W-1:0] d);
        bus.wr_en0 = 1'b1; bus.wr_addr0 = a; bus.wr_data0 = d;
    endtask

    task automatic wr1(input logic [LG-1:0] a, input logic [W-1:0] d);
        bus.wr_en1 = 1'b1; bus.wr_addr1 = a; bus.wr_data1 = d;
    endtask

    task automatic rd(input logic [LG-1:0] a);
        bus.rd_en = 1'b1; bus.rd_addr = a;
    endtask

    logic [W-1:0]  mem [D];
    logic          re, e0, e1;
    logic [LG-1:0] ra, a0, a1;
    logic [W-1:0]  d0, d1, exp_d;

    initial begin
        reset = 1'b1;
        bus.rd_addr = '0; bus.wr_addr0 = '0; bus.wr_addr1 = '0;
        bus.wr_data0 = '0; bus.wr_data1 = '0;
        idle();
        #1;
        chk("reset_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("reset_data", bus.rd_data, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_reset_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("post_reset_data", bus.rd_data, 32'h0);

        // Port 0 write then read, then port 1 overwrite
        wr0(4'd3, 32'hAAAA0003); tick(); idle();
        rd(4'd3); tick(); idle();
        chk("wr0_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("wr0_data", bus.rd_data, 32'hAAAA0003);
        wr1(4'd3, 32'hBBBB0003); tick(); idle();
        chk("idle_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("idle_data", bus.rd_data, 32'h0);
        rd(4'd3); tick(); idle();
        chk("wr1_data", bus.rd_data, 32'hBBBB0003);

        // Asynchronous reset mid-cycle while valid data is showing
        #3 reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("async_reset_data", bus.rd_data, 32'h0);
        wr0(4'd3, 32'hDEAD0003); tick(); idle();
        reset = 1'b0;
        tick();
        chk("after_reset_valid", {31'b0, bus.rd_valid}, 32'h0);
        // LVT cleared back to bank0, and the write during reset was dropped
        rd(4'd3); tick(); idle();
        chk("lvt_reset_data", bus.rd_data, 32'hAAAA0003);

        // Same-address collision: port 1 wins
        wr0(4'd5, 32'h11); wr1(4'd5, 32'h22); tick(); idle();
        rd(4'd5); tick(); idle();
        chk("collide_data", bus.rd_data, 32'h22);
        wr0(4'd5, 32'h33); tick(); idle();
        rd(4'd5); tick(); idle();
        chk("rewrite0_data", bus.rd_data, 32'h33);

        // Read-during-write returns old value (port 1, then port 0)
        wr0(4'd7, 32'h44); tick(); idle();
        wr1(4'd7, 32'h55); rd(4'd7); tick(); idle();
        chk("rdw1_old", bus.rd_data, 32'h44);
        rd(4'd7); tick(); idle();
        chk("rdw1_new", bus.rd_data, 32'h55);
        wr0(4'd7, 32'h66); rd(4'd7); tick(); idle();
        chk("rdw0_old", bus.rd_data, 32'h55);
        rd(4'd7); tick(); idle();
        chk("rdw0_new", bus.rd_data, 32'h66);

        // Dual writes to the end addresses, back-to-back reads
        wr0(4'd0, 32'h1); wr1(4'd15, 32'hF); tick(); idle();
        rd(4'd0); tick();
        chk("b2b0_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("b2b0_data", bus.rd_data, 32'h1);
        rd(4'd15); tick(); idle();
        chk("b2b1_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("b2b1_data", bus.rd_data, 32'hF);
        tick();
        chk("b2b_drop_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("b2b_drop_data", bus.rd_data, 32'h0);

        // Randomized traffic against a read-old model; fill every address first
        for (int i = 0; i < D; i++) begin
            d0 = $urandom;
            if (i % 2 == 0) wr0(LG'(i), d0); else wr1(LG'(i), d0);
            mem[i] = d0;
            tick(); idle();
        end
        for (int n = 0; n < 3000; n++) begin
            re = 1'($urandom); e0 = 1'($urandom); e1 = 1'($urandom);
            ra = LG'($urandom); a0 = LG'($urandom); a1 = LG'($urandom);
            d0 = $urandom; d1 = $urandom;
            bus.rd_en = re; bus.rd_addr = ra;
            bus.wr_en0 = e0; bus.wr_addr0 = a0; bus.wr_data0 = d0;
            bus.wr_en1 = e1; bus.wr_addr1 = a1; bus.wr_data1 = d1;
            exp_d = re ? mem[ra] : '0;
            if (e0) mem[a0] = d0;
            if (e1) mem[a1] = d1;
            tick();
            chk("rand_valid", {31'b0, bus.rd_valid}, {31'b0, re});
            chk("rand_data", bus.rd_data, exp_d);
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
